// File: rtl/byte_freq_counter.sv
// Splits 32-bit file words into bytes and builds a 256-entry frequency table, with handshakes back to the bus.
// Optional FREQ_SATURATE_EN: table entries saturate instead of wrapping, and a sticky "saturated" port appears.
module byte_freq_counter #(
  parameter int CNT_W   = 16,
  parameter int FSIZE_W = 16
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic               start,
  input  logic               stop,
  input  logic [FSIZE_W-1:0] file_size,
  input  logic [31:0]        data_save,
  input  logic               data_valid,
  output logic               done_four_bit,
  output logic               finish_cnt,
  output logic               overrun,
  output logic               short_file,
`ifdef FREQ_SATURATE_EN
  output logic               saturated,
`endif
  output logic [FSIZE_W-1:0] byte_count,
  input  logic [7:0]         freq_addr,
  output logic [CNT_W-1:0]   freq_data
);

  typedef enum logic [1:0] {IDLE, ARMED, SPLIT, FINISH} state_t;

  state_t             state_q;
  logic [31:0]        word_q;
  logic [1:0]         idx_q;
  logic [FSIZE_W-1:0] total_q;
  logic [FSIZE_W-1:0] cnt_q;
  logic               overrun_q;
  logic               short_q;
  logic               stop_pend_q;
  logic               got_word_q;
  logic [CNT_W-1:0]   freq_q;
  logic [CNT_W-1:0]   tbl_q [0:255];

  logic [7:0]         cur_byte_d;
  logic [FSIZE_W-1:0] cnt_d;
  logic [FSIZE_W-1:0] total_d;
  logic               last_byte_d;
  logic               word_end_d;
  logic [CNT_W-1:0]   tbl_old_d;
  logic [CNT_W-1:0]   tbl_new_d;
`ifdef FREQ_SATURATE_EN
  logic               sat_hit_d;
  logic               sat_flag_q;
`endif

  always_comb begin
    cur_byte_d = word_q[7:0];
    case (idx_q)
      2'd0: cur_byte_d = word_q[7:0];
      2'd1: cur_byte_d = word_q[15:8];
      2'd2: cur_byte_d = word_q[23:16];
      default: cur_byte_d = word_q[31:24];
    endcase
  end

  assign cnt_d       = cnt_q + {{(FSIZE_W-1){1'b0}}, 1'b1};
  assign last_byte_d = (cnt_d == total_q);
  assign word_end_d  = (idx_q == 2'd3) || last_byte_d;
  // The file length is only trusted when the first word of a file arrives.
  assign total_d     = (cnt_q == '0) ? file_size : total_q;
  assign tbl_old_d   = tbl_q[cur_byte_d];

`ifdef FREQ_SATURATE_EN
  always_comb begin
    sat_hit_d = (tbl_old_d == {CNT_W{1'b1}});
    tbl_new_d = sat_hit_d ? tbl_old_d : tbl_old_d + CNT_W'(1);
  end
  assign saturated = sat_flag_q;
`else
  assign tbl_new_d = tbl_old_d + CNT_W'(1);
`endif

  assign done_four_bit = (state_q == SPLIT) && word_end_d;
  assign finish_cnt    = (state_q == FINISH);
  assign overrun       = overrun_q;
  assign short_file    = short_q;
  assign byte_count    = cnt_q;
  assign freq_data     = freq_q;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= IDLE;
      word_q      <= '0;
      idx_q       <= '0;
      total_q     <= '0;
      cnt_q       <= '0;
      overrun_q   <= 1'b0;
      short_q     <= 1'b0;
      stop_pend_q <= 1'b0;
      got_word_q  <= 1'b0;
      freq_q      <= '0;
`ifdef FREQ_SATURATE_EN
      sat_flag_q  <= 1'b0;
`endif
      for (int i = 0; i < 256; i++) tbl_q[i] <= '0;
    end else begin
      freq_q <= tbl_q[freq_addr];
      if (start) begin
        state_q     <= ARMED;
        idx_q       <= '0;
        cnt_q       <= '0;
        overrun_q   <= 1'b0;
        short_q     <= 1'b0;
        stop_pend_q <= 1'b0;
        got_word_q  <= 1'b0;
`ifdef FREQ_SATURATE_EN
        sat_flag_q  <= 1'b0;
`endif
        for (int i = 0; i < 256; i++) tbl_q[i] <= '0;
      end else begin
        case (state_q)
          IDLE: ;
          ARMED: begin
            if (data_valid) begin
              word_q      <= data_save;
              got_word_q  <= 1'b1;
              idx_q       <= '0;
              total_q     <= total_d;
              stop_pend_q <= stop;
              state_q     <= (total_d == '0) ? FINISH : SPLIT;
            end else if (stop) begin
              state_q <= FINISH;
              if ((cnt_q != total_q) || !got_word_q) short_q <= 1'b1;
            end
          end
          SPLIT: begin
            tbl_q[cur_byte_d] <= tbl_new_d;
            cnt_q             <= cnt_d;
`ifdef FREQ_SATURATE_EN
            if (sat_hit_d) sat_flag_q <= 1'b1;
`endif
            if (data_valid) overrun_q <= 1'b1;
            if (word_end_d) begin
              stop_pend_q <= 1'b0;
              if (last_byte_d) begin
                state_q <= FINISH;
              end else if (stop || stop_pend_q) begin
                state_q <= FINISH;
                short_q <= 1'b1;
              end else begin
                state_q <= ARMED;
              end
            end else begin
              idx_q <= idx_q + 2'd1;
              if (stop) stop_pend_q <= 1'b1;
            end
          end
          FINISH: begin
            if (data_valid) overrun_q <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_byte_freq_counter.sv
// Directed bench for byte_freq_counter: a CNT_W=16 instance for function, a CNT_W=2 instance for wrap/saturation.
module tb_byte_freq_counter;
  logic        HCLK, HRESET, start, stop, data_valid;
  logic [15:0] file_size;
  logic [31:0] data_save;
  logic [7:0]  freq_addr;

  logic        done_four_bit, finish_cnt, overrun, short_file;
  logic [15:0] byte_count, freq_data;
  logic        s_done, s_finish, s_overrun, s_short;
  logic [15:0] s_byte_count;
  logic [1:0]  s_freq_data;
`ifdef FREQ_SATURATE_EN
  logic        saturated, s_saturated;
`endif

  int errors = 0;
  int checks = 0;

  byte_freq_counter #(.CNT_W(16), .FSIZE_W(16)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .stop(stop), .file_size(file_size),
    .data_save(data_save), .data_valid(data_valid), .done_four_bit(done_four_bit),
    .finish_cnt(finish_cnt), .overrun(overrun), .short_file(short_file),
`ifdef FREQ_SATURATE_EN
    .saturated(saturated),
`endif
    .byte_count(byte_count), .freq_addr(freq_addr), .freq_data(freq_data)
  );

  byte_freq_counter #(.CNT_W(2), .FSIZE_W(16)) dut_small (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .stop(stop), .file_size(file_size),
    .data_save(data_save), .data_valid(data_valid), .done_four_bit(s_done),
    .finish_cnt(s_finish), .overrun(s_overrun), .short_file(s_short),
`ifdef FREQ_SATURATE_EN
    .saturated(s_saturated),
`endif
    .byte_count(s_byte_count), .freq_addr(freq_addr), .freq_data(s_freq_data)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_start(input logic [15:0] fsz);
    file_size = fsz;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Leaves the bench in cycle 1 (first byte-count cycle) after the word is sampled.
  task automatic send_word(input logic [31:0] w);
    data_save  = w;
    data_valid = 1'b1;
    cyc();
    data_valid = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [15:0] exp);
    freq_addr = a;
    cyc();
    chk(tag, freq_data, exp);
  endtask

  task automatic wait_fin(input string tag);
    int n = 0;
    while (!finish_cnt && n < 20) begin
      cyc();
      n++;
    end
    chk(tag, finish_cnt, 1);
  endtask

  initial begin
    HRESET = 1'b1; start = 1'b0; stop = 1'b0; data_valid = 1'b0;
    file_size = '0; data_save = '0; freq_addr = '0;
    cyc(); cyc();
    chk("rst_done", done_four_bit, 0);
    chk("rst_finish", finish_cnt, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_short", short_file, 0);
    chk("rst_bytecnt", byte_count, 0);
    chk("rst_freq", freq_data, 0);
    HRESET = 1'b0;
    cyc();

    // One full word, exact done/finish timing.
    do_start(16'd4);
    send_word(32'h4443_4241);
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("t1_done_c%0d", c), done_four_bit, (c == 4));
      cyc();
    end
    chk("t1_done_c5", done_four_bit, 0);
    chk("t1_finish_c5", finish_cnt, 1);
    chk("t1_bytecnt", byte_count, 4);
    for (int b = 8'h41; b <= 8'h44; b++) rd_chk($sformatf("t1_tbl_%0h", b), 8'(b), 16'd1);
    rd_chk("t1_tbl_45", 8'h45, 16'd0);

    // Repeated bytes, then a partial final word.
    do_start(16'd6);
    rd_chk("t2_cleared", 8'h41, 16'd0);
    send_word(32'h4141_4141);
    cyc(); cyc(); cyc();
    chk("t2_done_w1", done_four_bit, 1);
    cyc();
    chk("t2_armed_fin", finish_cnt, 0);
    chk("t2_mid_cnt", byte_count, 4);
    send_word(32'h0000_4242);
    chk("t2_done_b0", done_four_bit, 0);
    cyc();
    chk("t2_done_b1", done_four_bit, 1);
    cyc();
    chk("t2_finish", finish_cnt, 1);
    chk("t2_bytecnt", byte_count, 6);
    rd_chk("t2_tbl_41", 8'h41, 16'd4);
    rd_chk("t2_tbl_42", 8'h42, 16'd2);
    rd_chk("t2_tbl_00", 8'h00, 16'd0);

    // Word arriving while busy is dropped and flagged.
    do_start(16'd4);
    chk("t3_overrun_clr", overrun, 0);
    send_word(32'h4443_4241);
    cyc();
    send_word(32'h5555_5555);
    wait_fin("t3_fin");
    chk("t3_overrun", overrun, 1);
    chk("t3_bytecnt", byte_count, 4);
    rd_chk("t3_tbl_55", 8'h55, 16'd0);
    rd_chk("t3_tbl_41", 8'h41, 16'd1);

    // Early stop from the bus.
    do_start(16'd8);
    send_word(32'h0102_0304);
    cyc(); cyc(); cyc(); cyc();
    chk("t4_armed", finish_cnt, 0);
    chk("t4_short_pre", short_file, 0);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("t4_finish", finish_cnt, 1);
    chk("t4_short", short_file, 1);
    chk("t4_bytecnt", byte_count, 4);
    rd_chk("t4_tbl_01", 8'h01, 16'd1);

    // Stop in the same cycle as the last byte is not a short file.
    do_start(16'd4);
    chk("t5_short_clr", short_file, 0);
    send_word(32'h0A0B_0C0D);
    cyc(); cyc(); cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("t5_finish", finish_cnt, 1);
    chk("t5_short", short_file, 0);

    // Reset in the middle of a word.
    do_start(16'd4);
    send_word(32'h4443_4241);
    cyc(); cyc();
    HRESET = 1'b1;
    cyc();
    HRESET = 1'b0;
    chk("t6_done", done_four_bit, 0);
    chk("t6_finish", finish_cnt, 0);
    chk("t6_bytecnt", byte_count, 0);
    rd_chk("t6_tbl_41", 8'h41, 16'd0);
    rd_chk("t6_tbl_42", 8'h42, 16'd0);
    send_word(32'h4141_4141);
    cyc();
    chk("t6_idle_ignore", byte_count, 0);
    do_start(16'd4);
    send_word(32'h4443_4241);
    wait_fin("t6_fin");
    rd_chk("t6_tbl_41b", 8'h41, 16'd1);
    rd_chk("t6_tbl_44b", 8'h44, 16'd1);

    // Zero-length file finishes without counting.
    do_start(16'd0);
    send_word(32'h4141_4141);
    chk("t7_finish", finish_cnt, 1);
    chk("t7_bytecnt", byte_count, 0);
    rd_chk("t7_tbl_41", 8'h41, 16'd0);

    // Five 0x41 bytes into a 2-bit counter: wrap or saturate.
    do_start(16'd5);
    send_word(32'h4141_4141);
    cyc(); cyc(); cyc(); cyc();
    send_word(32'h0000_0041);
    chk("t8_done", done_four_bit, 1);
    cyc();
    chk("t8_finish", s_finish, 1);
    rd_chk("t8_big_41", 8'h41, 16'd5);
`ifdef FREQ_SATURATE_EN
    chk("t8_small_41", s_freq_data, 3);
    chk("t8_sat_small", s_saturated, 1);
    chk("t8_sat_big", saturated, 0);
`else
    chk("t8_small_41", s_freq_data, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
